// File: rtl/split_3o.sv
//------------------------------------------------------------------------------
// Module   : split_3o
// Purpose  : Splits a channel-concatenated pixel stream into three branch
//            outputs by position (C1 maps, then C2 maps, then C3 maps).
// Options  : SPLIT_3O_MAP_FLAGS_EN adds per-branch map_last_k outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module split_3o #(
  parameter int WIDTH      = 35,
  parameter int C1         = 1,
  parameter int C2         = 1,
  parameter int C3         = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out_1,
  output logic                  valid_out_1,
  output logic [DATA_WIDTH-1:0] pxl_out_2,
  output logic                  valid_out_2,
  output logic [DATA_WIDTH-1:0] pxl_out_3,
  output logic                  valid_out_3,
`ifdef SPLIT_3O_MAP_FLAGS_EN
  output logic                  map_last_1,
  output logic                  map_last_2,
  output logic                  map_last_3,
`endif
  output logic                  frame_done
);

  localparam int NPIX  = WIDTH * WIDTH;
  localparam int CMAX  = (C1 > C2) ? ((C1 > C3) ? C1 : C3) : ((C2 > C3) ? C2 : C3);
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    S_BR1 = 2'd0,
    S_BR2 = 2'd1,
    S_BR3 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pix_cnt_q;
  logic [CW-1:0]         ch_cnt_q;
  logic [DATA_WIDTH-1:0] pxl_out_1_q, pxl_out_2_q, pxl_out_3_q;
  logic                  valid_out_1_q, valid_out_2_q, valid_out_3_q;
  logic                  frame_done_q;
  logic                  pix_last_w;
  logic                  ch_last_w;

  assign pix_last_w = (pix_cnt_q == PW'(NPIX - 1));

  // Map-count limit and successor branch depend on the branch being filled.
  always_comb begin
    ch_last_w = 1'b0;
    state_d   = S_BR1;
    case (state_q)
      S_BR1: begin
        ch_last_w = (ch_cnt_q == CW'(C1 - 1));
        state_d   = S_BR2;
      end
      S_BR2: begin
        ch_last_w = (ch_cnt_q == CW'(C2 - 1));
        state_d   = S_BR3;
      end
      S_BR3: begin
        ch_last_w = (ch_cnt_q == CW'(C3 - 1));
        state_d   = S_BR1;
      end
      default: begin
        ch_last_w = 1'b1;
        state_d   = S_BR1;
      end
    endcase
  end

`ifdef SPLIT_3O_MAP_FLAGS_EN
  logic map_last_1_q, map_last_2_q, map_last_3_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BR1;
      pix_cnt_q     <= '0;
      ch_cnt_q      <= '0;
      pxl_out_1_q   <= '0;
      pxl_out_2_q   <= '0;
      pxl_out_3_q   <= '0;
      valid_out_1_q <= 1'b0;
      valid_out_2_q <= 1'b0;
      valid_out_3_q <= 1'b0;
      frame_done_q  <= 1'b0;
`ifdef SPLIT_3O_MAP_FLAGS_EN
      map_last_1_q  <= 1'b0;
      map_last_2_q  <= 1'b0;
      map_last_3_q  <= 1'b0;
`endif
    end else begin
      valid_out_1_q <= valid_in && (state_q == S_BR1);
      valid_out_2_q <= valid_in && (state_q == S_BR2);
      valid_out_3_q <= valid_in && (state_q == S_BR3);
      frame_done_q  <= valid_in && pix_last_w && ch_last_w && (state_q == S_BR3);
`ifdef SPLIT_3O_MAP_FLAGS_EN
      map_last_1_q  <= valid_in && pix_last_w && (state_q == S_BR1);
      map_last_2_q  <= valid_in && pix_last_w && (state_q == S_BR2);
      map_last_3_q  <= valid_in && pix_last_w && (state_q == S_BR3);
`endif
      if (valid_in) begin
        if (state_q == S_BR1) pxl_out_1_q <= pxl_in;
        if (state_q == S_BR2) pxl_out_2_q <= pxl_in;
        if (state_q == S_BR3) pxl_out_3_q <= pxl_in;
        if (pix_last_w) begin
          pix_cnt_q <= '0;
          if (ch_last_w) begin
            ch_cnt_q <= '0;
            state_q  <= state_d;
          end else begin
            ch_cnt_q <= ch_cnt_q + 1'b1;
          end
        end else begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
        end
      end
    end
  end

  assign pxl_out_1   = pxl_out_1_q;
  assign pxl_out_2   = pxl_out_2_q;
  assign pxl_out_3   = pxl_out_3_q;
  assign valid_out_1 = valid_out_1_q;
  assign valid_out_2 = valid_out_2_q;
  assign valid_out_3 = valid_out_3_q;
  assign frame_done  = frame_done_q;
`ifdef SPLIT_3O_MAP_FLAGS_EN
  assign map_last_1  = map_last_1_q;
  assign map_last_2  = map_last_2_q;
  assign map_last_3  = map_last_3_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_split_3o.sv
//------------------------------------------------------------------------------
// Module   : tb_split_3o
// Purpose  : Scoreboard bench for split_3o (WIDTH=2, C1=1, C2=1, C3=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_split_3o;

  localparam int W     = 2;
  localparam int C1    = 1;
  localparam int C2    = 1;
  localparam int C3    = 2;
  localparam int DW    = 32;
  localparam int NPIX  = W * W;
  localparam int TOTAL = (C1 + C2 + C3) * NPIX;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic [DW-1:0] pxl_out_1, pxl_out_2, pxl_out_3;
  logic          valid_out_1, valid_out_2, valid_out_3;
  logic          frame_done;
  logic          map_last_1, map_last_2, map_last_3;

  split_3o #(.WIDTH(W), .C1(C1), .C2(C2), .C3(C3), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .pxl_in      (pxl_in),
    .pxl_out_1   (pxl_out_1),
    .valid_out_1 (valid_out_1),
    .pxl_out_2   (pxl_out_2),
    .valid_out_2 (valid_out_2),
    .pxl_out_3   (pxl_out_3),
    .valid_out_3 (valid_out_3),
`ifdef SPLIT_3O_MAP_FLAGS_EN
    .map_last_1  (map_last_1),
    .map_last_2  (map_last_2),
    .map_last_3  (map_last_3),
`endif
    .frame_done  (frame_done)
  );

`ifndef SPLIT_3O_MAP_FLAGS_EN
  assign map_last_1 = 1'b0;
  assign map_last_2 = 1'b0;
  assign map_last_3 = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int          br;
    logic [DW-1:0] d;
    bit          fd;
    bit          ml;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pos      = 0;   // position of the next pixel within the frame
  bit   mon_en   = 1'b0;
  bit   rst_seen = 1'b1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: branch chosen purely from frame position.
  function automatic exp_t model(input logic [DW-1:0] d, input int p);
    exp_t e;
    e.br = (p < C1 * NPIX) ? 1 : (p < (C1 + C2) * NPIX) ? 2 : 3;
    e.d  = d;
    e.fd = (p == TOTAL - 1);
    e.ml = ((p % NPIX) == NPIX - 1);
    return e;
  endfunction

  task automatic send(input logic [DW-1:0] d);
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b1;
    pxl_in   = d;
    exp_q.push_back(model(d, pos));
    pos = (pos + 1) % TOTAL;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset    = 1'b0;
      valid_in = 1'b0;
      pxl_in   = $urandom;
    end
  endtask

  task automatic do_reset(input bit v, input logic [DW-1:0] d);
    @(negedge clk);
    reset    = 1'b1;
    valid_in = v;
    pxl_in   = d;
    pos      = 0;
  endtask

  always @(posedge clk) rst_seen = reset;

  // Monitor: pops one expectation per valid output cycle.
  initial begin
    logic [DW-1:0] last1, last2, last3;
    last1 = '0; last2 = '0; last3 = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        int nv;
        nv = int'(valid_out_1) + int'(valid_out_2) + int'(valid_out_3);
        if (rst_seen) begin
          check("reset_state", {pxl_out_1 | pxl_out_2 | pxl_out_3},  '0);
          check("reset_flags", {29'd0, valid_out_1 | valid_out_2 | valid_out_3,
                                frame_done, map_last_1 | map_last_2 | map_last_3}, '0);
          last1 = '0; last2 = '0; last3 = '0;
        end else if (nv > 1) begin
          check("exclusive_valid", DW'(nv), 1);
        end else if (nv == 1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            int   br;
            logic [DW-1:0] d;
            logic ml;
            e  = exp_q.pop_front();
            br = valid_out_1 ? 1 : valid_out_2 ? 2 : 3;
            d  = valid_out_1 ? pxl_out_1 : valid_out_2 ? pxl_out_2 : pxl_out_3;
            ml = valid_out_1 ? map_last_1 : valid_out_2 ? map_last_2 : map_last_3;
            check("branch", DW'(br), DW'(e.br));
            check("data", d, e.d);
            check("frame_done", DW'(frame_done), DW'(e.fd));
`ifdef SPLIT_3O_MAP_FLAGS_EN
            check("map_last", DW'(ml), DW'(e.ml));
`endif
            if (valid_out_1) last1 = pxl_out_1;
            if (valid_out_2) last2 = pxl_out_2;
            if (valid_out_3) last3 = pxl_out_3;
          end
        end else begin
          check("idle_frame_done", DW'(frame_done), 0);
          check("hold_1", pxl_out_1, last1);
          check("hold_2", pxl_out_2, last2);
          check("hold_3", pxl_out_3, last3);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    idle(1);

    // Basic routing, then back-to-back second frame.
    for (int i = 1; i <= 32; i++) send(DW'(i));
    idle(2);

    // Gapped input.
    for (int i = 1; i <= 16; i++) begin
      send(DW'(100 + i));
      idle(1);
    end

    // Reset mid-frame after pixel 6, then a fresh frame.
    for (int i = 1; i <= 6; i++) send(DW'(i));
    do_reset(1'b0, '0);
    for (int i = 1; i <= 16; i++) send(DW'(i));
    idle(1);

    // Reset and valid collision: 99 must be dropped.
    send(DW'(1));
    do_reset(1'b1, DW'(99));
    for (int i = 1; i <= 16; i++) send(DW'(200 + i));
    idle(2);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       do_reset(1'($urandom_range(0, 1)), $urandom);
      else if (r < 30) idle(1);
      else             send($urandom);
    end
    idle(4);

    check("queue_drained", DW'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
